// File: rtl/frame_detector.sv
// frame_detector: plateau/trigger back end of the synchronization chain.
// Consumes the aligned per-sample metric bundle (sample, window energy,
// autocorrelation magnitude, accumulated phase). It detects the start and end
// of a preamble plateau and emits the samples as a framed stream.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   s_valid/s_ready         input bundle handshake
//   s_data                  sample {Q,I}
//   s_energy                window energy (signed)
//   s_magnitude             autocorrelation magnitude (signed)
//   s_frequency             accumulated phase (signed)
//   m_valid/m_ready         output handshake
//   m_data                  sample {Q,I}
//   m_user                  frequency estimate latched at detection
//   m_first/m_last          frame delimiters
//   detected                high while a frame is open
module frame_detector #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned METRIC_WIDTH = 32,
    parameter int unsigned PLATEAU      = 28,
    parameter int unsigned THRESH_NUM   = 3,
    parameter int unsigned THRESH_SHIFT = 2,
    parameter int unsigned AVG_SHIFT    = 4,
    parameter int unsigned MAX_FRAME    = 0,
    parameter int unsigned GATED        = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic        [2*WIDTH-1:0]      s_data,
    input  logic signed [METRIC_WIDTH-1:0] s_energy,
    input  logic signed [METRIC_WIDTH-1:0] s_magnitude,
    input  logic signed [METRIC_WIDTH-1:0] s_frequency,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic        [2*WIDTH-1:0]      m_data,
    output logic signed [METRIC_WIDTH-1:0] m_user,
    output logic                           m_first,
    output logic                           m_last,
    output logic                           detected
);

    // Threshold width leaves headroom for the numerator, so the product never wraps.
    localparam int unsigned TW = METRIC_WIDTH + $clog2(THRESH_NUM) + 1;
    localparam int unsigned CW = $clog2(PLATEAU + 1);
    localparam int unsigned LW = (MAX_FRAME == 0) ? 16 : $clog2(MAX_FRAME + 1);

    localparam logic signed [TW-1:0] NUM_S    = TW'(THRESH_NUM);
    localparam logic        [CW-1:0] CNT_LAST = CW'(PLATEAU - 1);
    localparam logic        [LW-1:0] LEN_MAX  = LW'(MAX_FRAME);
    localparam logic        [LW-1:0] LEN_SAT  = {LW{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ACTIVE,
        RELEASE,
        HOLDOFF
    } state_t;

    // Stage 1 registers
    logic                           s1_valid_q;
    logic        [2*WIDTH-1:0]      s1_data_q;
    logic signed [METRIC_WIDTH-1:0] s1_mag_q;
    logic signed [METRIC_WIDTH-1:0] s1_freq_q;
    logic signed [TW-1:0]           s1_thr_q;

    // Stage 2 / FSM registers
    state_t                         state_q;
    logic        [CW-1:0]           cnt_q;
    logic        [LW-1:0]           len_q;
    logic                           m_valid_q;
    logic        [2*WIDTH-1:0]      m_data_q;
    logic signed [METRIC_WIDTH-1:0] m_user_q;
    logic                           m_first_q;
    logic                           m_last_q;
    logic                           detected_q;

    logic                           en_c;
    logic signed [TW-1:0]           energy_ext_c;
    logic signed [TW-1:0]           thr_c;
    logic signed [METRIC_WIDTH-1:0] freq_avg_c;
    logic                           trigger_c;
    logic        [LW-1:0]           len_inc_c;
    logic                           len_hit_c;

    // Both stages advance together; a stalled output freezes everything.
    assign en_c    = !m_valid_q || m_ready;
    assign s_ready = en_c;

    assign energy_ext_c = TW'(s_energy);
    assign thr_c        = (energy_ext_c * NUM_S) >>> THRESH_SHIFT;
    assign freq_avg_c   = s_frequency >>> AVG_SHIFT;

    assign trigger_c = TW'(s1_mag_q) > s1_thr_q;

    // Frame length saturates so an unlimited frame never wraps back to zero.
    assign len_inc_c = (len_q == LEN_SAT) ? len_q : len_q + LW'(1);
    assign len_hit_c = (MAX_FRAME != 0) && (len_inc_c == LEN_MAX);

    // Pipeline registers and plateau FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mag_q   <= '0;
            s1_freq_q  <= '0;
            s1_thr_q   <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_user_q   <= '0;
            m_first_q  <= 1'b0;
            m_last_q   <= 1'b0;
            detected_q <= 1'b0;
        end else if (en_c) begin
            s1_valid_q <= s_valid;
            s1_data_q  <= s_data;
            s1_mag_q   <= s_magnitude;
            s1_freq_q  <= freq_avg_c;
            s1_thr_q   <= thr_c;

            // Out-of-frame samples are only forwarded in ungated mode.
            m_data_q   <= s1_data_q;
            m_valid_q  <= s1_valid_q && (GATED == 0);
            m_first_q  <= 1'b0;
            m_last_q   <= 1'b0;

            if (s1_valid_q) begin
                case (state_q)
                    IDLE: begin
                        if (trigger_c) begin
                            cnt_q   <= CW'(1);
                            state_q <= ARM;
                        end
                    end
                    ARM: begin
                        if (!trigger_c) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else if (cnt_q == CNT_LAST) begin
                            m_first_q <= 1'b1;
                            m_valid_q <= 1'b1;
                            m_user_q  <= s1_freq_q;
                            len_q     <= LW'(1);
                            cnt_q     <= '0;
                            // A one-sample frame closes on its own first sample.
                            if (MAX_FRAME == 1) begin
                                m_last_q <= 1'b1;
                                state_q  <= HOLDOFF;
                            end else begin
                                detected_q <= 1'b1;
                                state_q    <= ACTIVE;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ACTIVE: begin
                        m_valid_q <= 1'b1;
                        len_q     <= len_inc_c;
                        if (len_hit_c) begin
                            m_last_q   <= 1'b1;
                            detected_q <= 1'b0;
                            cnt_q      <= '0;
                            state_q    <= HOLDOFF;
                        end else if (!trigger_c) begin
                            cnt_q   <= CW'(1);
                            state_q <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        m_valid_q <= 1'b1;
                        len_q     <= len_inc_c;
                        if (len_hit_c) begin
                            m_last_q   <= 1'b1;
                            detected_q <= 1'b0;
                            cnt_q      <= '0;
                            state_q    <= HOLDOFF;
                        end else if (trigger_c) begin
                            cnt_q   <= '0;
                            state_q <= ACTIVE;
                        end else if (cnt_q == CNT_LAST) begin
                            m_last_q   <= 1'b1;
                            detected_q <= 1'b0;
                            cnt_q      <= '0;
                            state_q    <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    HOLDOFF: begin
                        // The releasing low sample does not itself start arming.
                        if (!trigger_c) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_user   = m_user_q;
    assign m_first  = m_first_q;
    assign m_last   = m_last_q;
    assign detected = detected_q;

endmodule
